// File: rtl/ifu_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller.
//   BITS_W     : width of PC, address and instruction word
//   PC_RST     : fetch PC after reset
//   PC_STEP    : sequential PC increment
//   RRESP_OKAY : read response code for a successful access
//   fetch_state_e : fetch sequencer states
package ifu_fetch_ctrl_pkg;

  localparam int unsigned       BITS_W     = 32;
  localparam logic [BITS_W-1:0] PC_RST     = 32'h8000_0000;
  localparam int unsigned       PC_STEP    = 4;
  localparam logic [1:0]        RRESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } fetch_state_e;

endpackage

// File: rtl/ifu_skid_buf.sv
// One-entry valid/ready buffer holding {pc, inst, fault} for the decode stage.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   flush_i         : drop the held entry (takes priority over a load)
//   in_valid_i      : load request
//   in_ready_o      : buffer can accept (empty, or draining this cycle)
//   in_pc_i, in_inst_i, in_fault_i : entry to load
//   out_valid_o, out_pc_o, out_inst_o, out_fault_o : held entry
//   out_ready_i     : consumer accepts the held entry
module ifu_skid_buf #(
  parameter int unsigned BITS_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [BITS_W-1:0] in_pc_i,
  input  logic [BITS_W-1:0] in_inst_i,
  input  logic              in_fault_i,
  output logic              out_valid_o,
  output logic [BITS_W-1:0] out_pc_o,
  output logic [BITS_W-1:0] out_inst_o,
  output logic              out_fault_o,
  input  logic              out_ready_i
);

  logic              valid_q, valid_d;
  logic [BITS_W-1:0] pc_q, pc_d;
  logic [BITS_W-1:0] inst_q, inst_d;
  logic              fault_q, fault_d;

  assign in_ready_o = !valid_q || out_ready_i;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    fault_d = fault_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (in_valid_i && in_ready_o) begin
      // Covers load-while-draining as well as load-into-empty.
      valid_d = 1'b1;
      pc_d    = in_pc_i;
      inst_d  = in_inst_i;
      fault_d = in_fault_i;
    end else if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      fault_q <= fault_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_pc_o    = pc_q;
  assign out_inst_o  = inst_q;
  assign out_fault_o = fault_q;

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Fetch-stage sequencer. Owns the fetch PC, issues one read at a time on a
// valid/ready address/data bus and hands {pc, inst, fault} to decode through
// a one-entry buffer. Redirects discard any in-flight response.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   redirect_valid, redirect_pc  : branch/exception redirect pulse and target
//   mem_arvalid/araddr/arready   : read address channel
//   mem_rvalid/rdata/rresp/rready: read data channel
//   out_valid/pc/inst/fault      : fetched instruction to decode
//   out_ready                    : decode accepts (low = stall)
module ifu_fetch_ctrl
  import ifu_fetch_ctrl_pkg::*;
#(
  parameter int unsigned       BITS_W  = ifu_fetch_ctrl_pkg::BITS_W,
  parameter logic [BITS_W-1:0] PC_RST  = ifu_fetch_ctrl_pkg::PC_RST,
  parameter int unsigned       PC_STEP = ifu_fetch_ctrl_pkg::PC_STEP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [BITS_W-1:0] redirect_pc,
  output logic              mem_arvalid,
  output logic [BITS_W-1:0] mem_araddr,
  input  logic              mem_arready,
  input  logic              mem_rvalid,
  input  logic [BITS_W-1:0] mem_rdata,
  input  logic [1:0]        mem_rresp,
  output logic              mem_rready,
  output logic              out_valid,
  output logic [BITS_W-1:0] out_pc,
  output logic [BITS_W-1:0] out_inst,
  output logic              out_fault,
  input  logic              out_ready
);

  fetch_state_e      state_q, state_d;
  logic [BITS_W-1:0] pc_q, pc_d;
  logic [BITS_W-1:0] araddr_q, araddr_d;
  logic              discard_q, discard_d;
  logic              buf_load;
  logic              buf_ready;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    araddr_d    = araddr_q;
    discard_d   = discard_q;
    mem_arvalid = 1'b0;
    mem_rready  = 1'b0;
    buf_load    = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        mem_arvalid = 1'b1;
        if (mem_arready) begin
          state_d = WAIT;
        end
        // The request already on the bus is for the old path; its response must go.
        if (redirect_valid) begin
          discard_d = 1'b1;
        end
      end
      WAIT: begin
        mem_rready = buf_ready;
        if (mem_rvalid && buf_ready) begin
          state_d = REQ;
          if (discard_q || redirect_valid) begin
            discard_d = 1'b0;
          end else begin
            buf_load = 1'b1;
            pc_d     = pc_q + BITS_W'(PC_STEP);
          end
        end else if (redirect_valid) begin
          discard_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (redirect_valid) begin
      pc_d = redirect_pc;
    end

    // Address is captured only on entry to REQ so it stays put until accepted,
    // even if a redirect moves pc meanwhile.
    if (state_d == REQ && state_q != REQ) begin
      araddr_d = pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= PC_RST;
      araddr_q  <= PC_RST;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      araddr_q  <= araddr_d;
      discard_q <= discard_d;
    end
  end

  assign mem_araddr = araddr_q;

  ifu_skid_buf #(
    .BITS_W(BITS_W)
  ) u_skid_buf (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (redirect_valid),
    .in_valid_i  (buf_load),
    .in_ready_o  (buf_ready),
    .in_pc_i     (pc_q),
    .in_inst_i   (mem_rdata),
    .in_fault_i  (mem_rresp != RRESP_OKAY),
    .out_valid_o (out_valid),
    .out_pc_o    (out_pc),
    .out_inst_o  (out_inst),
    .out_fault_o (out_fault),
    .out_ready_i (out_ready)
  );

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed bench for ifu_fetch_ctrl. A small memory responder returns
// inst = addr + 0x1000_0000, with programmable arready/rvalid delays and one
// faulting address. Expected values are hand-derived constants.
module tb_ifu_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_arvalid;
  logic [31:0] mem_araddr;
  logic        mem_arready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_rresp;
  logic        mem_rready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_fault;
  logic        out_ready = 1'b1;

  int n_chk  = 0;
  int n_pass = 0;

  // Memory responder controls
  int          ar_delay   = 0;
  int          r_delay    = 0;
  logic [31:0] fault_addr = 32'h0000_0001;

  logic [31:0] ar_log[$];
  logic [31:0] out_pc_log[$];
  logic [31:0] out_inst_log[$];
  logic [31:0] out_flt_log[$];

  ifu_fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_arvalid    (mem_arvalid),
    .mem_araddr     (mem_araddr),
    .mem_arready    (mem_arready),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .mem_rresp      (mem_rresp),
    .mem_rready     (mem_rready),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_fault      (out_fault),
    .out_ready      (out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Memory model: handshakes sampled at negedge, outputs driven #1 after posedge.
  initial begin : mem_model
    logic        ar_hs, r_hs, pend;
    logic [31:0] addr_s, pend_addr;
    int          ar_cnt, r_cnt;
    mem_arready = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = '0;
    mem_rresp   = '0;
    pend        = 1'b0;
    pend_addr   = '0;
    ar_cnt      = 0;
    r_cnt       = 0;
    forever begin
      @(negedge clk);
      ar_hs  = mem_arvalid & mem_arready;
      r_hs   = mem_rvalid & mem_rready;
      addr_s = mem_araddr;
      @(posedge clk);
      #1;
      if (rst) begin
        mem_arready = 1'b0;
        mem_rvalid  = 1'b0;
        pend        = 1'b0;
        ar_cnt      = 0;
      end else begin
        if (r_hs) begin
          mem_rvalid = 1'b0;
          pend       = 1'b0;
        end
        if (ar_hs) begin
          mem_arready = 1'b0;
          pend        = 1'b1;
          pend_addr   = addr_s;
          r_cnt       = r_delay;
          ar_cnt      = 0;
        end
        if (!pend && !mem_arready && mem_arvalid) begin
          if (ar_cnt >= ar_delay) mem_arready = 1'b1;
          else ar_cnt++;
        end
        if (pend && !mem_rvalid) begin
          if (r_cnt == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = pend_addr + 32'h1000_0000;
            mem_rresp  = (pend_addr == fault_addr) ? 2'd2 : 2'd0;
          end else begin
            r_cnt--;
          end
        end
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_arvalid && mem_arready) ar_log.push_back(mem_araddr);
        if (out_valid && out_ready) begin
          out_pc_log.push_back(out_pc);
          out_inst_log.push_back(out_inst);
          out_flt_log.push_back({31'd0, out_fault});
        end
      end
    end
  end

  task automatic clear_logs();
    ar_log.delete();
    out_pc_log.delete();
    out_inst_log.delete();
    out_flt_log.delete();
  endtask

  // One-cycle redirect; out_ready is set alongside. Logs restart afterwards.
  task automatic pulse(input logic [31:0] tgt, input logic ordy);
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    out_ready      = ordy;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    clear_logs();
  endtask

  task automatic wait_out(input string tag, input int n, input int max_cyc);
    int c;
    c = 0;
    while (out_pc_log.size() < n && c < max_cyc) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_timeout"}, 32'(out_pc_log.size() >= n), 32'd1);
  endtask

  task automatic wait_ar(input string tag);
    int found;
    found = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mem_arvalid && mem_arready) begin
        found = 1;
        break;
      end
    end
    chk({tag, "_ar_hs"}, 32'(found), 32'd1);
  endtask

  initial begin : stim
    int i1, i2, bad, rr_bad, found, hs;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arvalid", 32'(mem_arvalid), 32'd0);
    chk("rst_araddr", mem_araddr, 32'h8000_0000);
    chk("rst_rready", 32'(mem_rready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_out_fault", 32'(out_fault), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_logs();

    // Zero-wait sequential fetch and first-output latency
    i1 = -1;
    i2 = -1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (i1 < 0 && mem_arvalid && mem_arready) i1 = c;
      if (out_valid) begin
        i2 = c;
        break;
      end
    end
    chk("seq_latency", 32'(i2 - i1), 32'd2);
    wait_out("seq", 3, 40);
    chk("seq_ar0", ar_log[0], 32'h8000_0000);
    chk("seq_ar1", ar_log[1], 32'h8000_0004);
    chk("seq_ar2", ar_log[2], 32'h8000_0008);
    chk("seq_pc0", out_pc_log[0], 32'h8000_0000);
    chk("seq_pc1", out_pc_log[1], 32'h8000_0004);
    chk("seq_pc2", out_pc_log[2], 32'h8000_0008);
    chk("seq_inst0", out_inst_log[0], 32'h9000_0000);

    // Redirect while waiting on a slow response
    @(posedge clk);
    #1;
    r_delay = 3;
    wait_ar("wait_redir");
    pulse(32'h8000_1000, 1'b1);
    r_delay = 0;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    chk("wait_redir_no_out", 32'(bad), 32'd0);
    wait_out("wait_redir", 1, 40);
    chk("wait_redir_ar", ar_log[0], 32'h8000_1000);
    chk("wait_redir_pc", out_pc_log[0], 32'h8000_1000);
    chk("wait_redir_inst", out_inst_log[0], 32'h9000_1000);

    // Redirect in the same cycle as the rvalid/rready handshake
    wait_ar("coinc");
    pulse(32'h8000_2000, 1'b1);
    wait_out("coinc", 2, 40);
    chk("coinc_ar", ar_log[0], 32'h8000_2000);
    chk("coinc_pc0", out_pc_log[0], 32'h8000_2000);
    chk("coinc_pc1", out_pc_log[1], 32'h8000_2004);

    // Stall with the buffer full
    pulse(32'h8000_3000, 1'b0);
    found = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid) begin
        found = 1;
        break;
      end
    end
    chk("stall_fill", 32'(found), 32'd1);
    chk("stall_pc", out_pc, 32'h8000_3000);
    chk("stall_inst", out_inst, 32'h9000_3000);
    bad = 0;
    rr_bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_rready) rr_bad++;
      if (!out_valid || out_pc !== 32'h8000_3000 || out_inst !== 32'h9000_3000) bad++;
    end
    chk("stall_rready", 32'(rr_bad), 32'd0);
    chk("stall_stable", 32'(bad), 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_out("stall", 3, 40);
    chk("stall_pc0", out_pc_log[0], 32'h8000_3000);
    chk("stall_pc1", out_pc_log[1], 32'h8000_3004);
    chk("stall_pc2", out_pc_log[2], 32'h8000_3008);

    // Access fault delivered, fetch continues sequentially
    fault_addr = 32'h8000_0010;
    pulse(32'h8000_0010, 1'b1);
    wait_out("fault", 2, 40);
    chk("fault_pc0", out_pc_log[0], 32'h8000_0010);
    chk("fault_flt0", out_flt_log[0], 32'd1);
    chk("fault_pc1", out_pc_log[1], 32'h8000_0014);
    chk("fault_flt1", out_flt_log[1], 32'd0);
    chk("fault_ar1", ar_log[1], 32'h8000_0014);
    fault_addr = 32'h0000_0001;

    // Slow arready with a redirect during the held request
    pulse(32'h8000_4000, 1'b1);
    found = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid && out_pc == 32'h8000_4000) begin
        found = 1;
        break;
      end
    end
    chk("arhold_start", 32'(found), 32'd1);
    ar_delay = 4;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_arvalid && !mem_arready) break;
    end
    chk("arhold_addr", mem_araddr, 32'h8000_4008);
    pulse(32'h8000_5000, 1'b1);
    bad = 0;
    hs = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_arvalid && mem_araddr !== 32'h8000_4008) bad++;
      if (mem_arvalid && mem_arready) begin
        hs = 1;
        break;
      end
    end
    chk("arhold_stable", 32'(bad), 32'd0);
    chk("arhold_hs", 32'(hs), 32'd1);
    wait_out("arhold", 1, 80);
    chk("arhold_ar0", ar_log[0], 32'h8000_4008);
    chk("arhold_ar1", ar_log[1], 32'h8000_5000);
    chk("arhold_pc0", out_pc_log[0], 32'h8000_5000);
    ar_delay = 0;

    // PC wraps at the top of the address space
    pulse(32'hFFFF_FFFC, 1'b1);
    wait_out("wrap", 2, 40);
    chk("wrap_ar0", ar_log[0], 32'hFFFF_FFFC);
    chk("wrap_ar1", ar_log[1], 32'h0000_0000);
    chk("wrap_pc1", out_pc_log[1], 32'h0000_0000);
    chk("wrap_inst1", out_inst_log[1], 32'h1000_0000);

    // Reset in the middle of a transaction
    @(posedge clk);
    #1;
    r_delay = 3;
    wait_ar("midrst");
    @(posedge clk);
    #1;
    rst = 1'b1;
    r_delay = 0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_araddr", mem_araddr, 32'h8000_0000);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_arvalid", 32'(mem_arvalid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_logs();
    wait_out("midrst", 1, 40);
    chk("midrst_ar0", ar_log[0], 32'h8000_0000);
    chk("midrst_pc0", out_pc_log[0], 32'h8000_0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
